// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NREQ requesters, launches the
// granted byte and reports done/err per requester.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [7:0]        to_uart,
    output logic              tx_external,
    input  logic              uart_busy,
    input  logic              end_tx,
    output logic [2:0]        state_out
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = $clog2(GAP_CYC + 1);

    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CntMax  = CW'(TIMEOUT);
    localparam logic [GW-1:0] GapLast = GW'(GAP_CYC - 1);
    localparam logic [PW-1:0] PtrInit = PW'(NREQ - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLoad     = 3'd1,
        StWaitBusy = 3'd2,
        StWaitEnd  = 3'd3,
        StDone     = 3'd4,
        StErr      = 3'd5,
        StGap      = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [7:0]      to_uart_q, to_uart_d;
    logic            tx_q, tx_d;

    logic            rr_found;
    logic [PW-1:0]   rr_sel;
    logic [PW-1:0]   scan_idx;

    // First requester after the last owner wins, so a repeat requester goes last.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        scan_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = PW'((32'(ptr_q) + k) % NREQ);
            if (!rr_found && req[scan_idx]) begin
                rr_found = 1'b1;
                rr_sel   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        to_uart_d = to_uart_q;
        tx_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (rr_found) begin
                    state_d         = StLoad;
                    sel_d           = rr_sel;
                    grant_d         = '0;
                    grant_d[rr_sel] = 1'b1;
                    to_uart_d       = req_data[8*rr_sel +: 8];
                end
            end
            StLoad: begin
                state_d = StWaitBusy;
                tx_d    = 1'b1;
                cnt_d   = '0;
            end
            StWaitBusy, StWaitEnd: begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
                // end_tx outranks the timeout landing in the same cycle
                if (end_tx) begin
                    state_d       = StDone;
                    grant_d       = '0;
                    done_d[sel_q] = 1'b1;
                end else if (cnt_q >= CntLast) begin
                    state_d      = StErr;
                    grant_d      = '0;
                    err_d[sel_q] = 1'b1;
                end else if (state_q == StWaitBusy && uart_busy) begin
                    state_d = StWaitEnd;
                end
            end
            StDone, StErr: begin
                ptr_d   = sel_q;
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                if (gap_q >= GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= PtrInit;
            sel_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            to_uart_q <= '0;
            tx_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            to_uart_q <= to_uart_d;
            tx_q      <= tx_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign err         = err_q;
    assign to_uart     = to_uart_q;
    assign tx_external = tx_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a behavioural uart_tx responder plus a
// transaction-level round-robin/timing model drive randomized transfers.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;
    localparam int GAP_CYC = 2;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic [NREQ-1:0]   req       = '0;
    logic [8*NREQ-1:0] req_data  = '0;
    logic              uart_busy = 1'b0;
    logic              end_tx    = 1'b0;
    logic [NREQ-1:0]   grant, done, err;
    logic [7:0]        to_uart;
    logic              tx_external;
    logic [2:0]        state_out;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    int exp_ptr = NREQ - 1;
    // responder: 0 silent, 1 busy then end_tx, 2 end_tx only, 3 random noise
    int resp_mode = 0;
    int busy_at   = 0;
    int end_at    = 0;
    int since_tx  = -1;
    logic [7:0] rdata [NREQ];

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .done        (done),
        .err         (err),
        .to_uart     (to_uart),
        .tx_external (tx_external),
        .uart_busy   (uart_busy),
        .end_tx      (end_tx),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    // Behavioural uart_tx: offsets count cycles from the tx_external pulse.
    always @(negedge clk) begin
        if (rst) since_tx = -1;
        else if (tx_external) since_tx = 0;
        else if (since_tx >= 0) since_tx++;
        uart_busy = 1'b0;
        end_tx    = 1'b0;
        if (resp_mode == 3) begin
            uart_busy = 1'($urandom_range(0, 1));
            end_tx    = 1'($urandom_range(0, 1));
        end else if (since_tx >= 0) begin
            if (resp_mode == 1 && since_tx >= busy_at && since_tx < end_at) uart_busy = 1'b1;
            if ((resp_mode == 1 || resp_mode == 2) && since_tx == end_at) begin
                end_tx   = 1'b1;
                since_tx = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (!$onehot0(grant) || !$onehot0(done) || !$onehot0(err) || (|done && |err)))
            viol++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (((m >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = rdata[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        resp_mode = 0;
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_ptr = NREQ - 1;
    endtask

    // which: 0 grant, 1 tx_external, 2 done or err; n = negedges waited, -1 on expiry
    task automatic wait_sig(input int which, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((which == 0 && grant != '0) || (which == 1 && tx_external) ||
                (which == 2 && (done != '0 || err != '0))) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        req = 2'b11;
        req_data = 16'hBEEF;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin $display("FAIL reset_grant: got %b want 00", grant); errors++; end
        checks++; if (done !== 2'b00 || err !== 2'b00) begin $display("FAIL reset_done_err: got %b/%b want 00/00", done, err); errors++; end
        checks++; if (to_uart !== 8'h00) begin $display("FAIL reset_to_uart: got %h want 00", to_uart); errors++; end
        checks++; if (tx_external !== 1'b0) begin $display("FAIL reset_tx: got %b want 0", tx_external); errors++; end
        checks++; if (state_out !== 3'd0) begin $display("FAIL reset_state: got %0d want 0", state_out); errors++; end
        repeat (3) begin
            tick();
            checks++; if (grant !== 2'b00) begin $display("FAIL reset_hold_grant: got %b want 00", grant); errors++; end
        end
        do_reset();
    endtask

    task automatic test_single();
        int n;
        do_reset();
        resp_mode = 1; busy_at = 1; end_at = 4;
        rdata[0] = 8'hA5; rdata[1] = 8'h3C; drive_data();
        req = 2'b01;
        wait_sig(0, 10, n);
        checks++; if (n !== 1 || grant !== 2'b01) begin $display("FAIL single_grant: got %b after %0d want 01 after 1", grant, n); errors++; end
        checks++; if (to_uart !== 8'hA5) begin $display("FAIL single_data: got %h want a5", to_uart); errors++; end
        checks++; if (tx_external !== 1'b0) begin $display("FAIL single_early_tx: got %b want 0", tx_external); errors++; end
        wait_sig(1, 10, n);
        checks++; if (n !== 1) begin $display("FAIL single_launch: got %0d want 1", n); errors++; end
        tick();
        checks++; if (tx_external !== 1'b0) begin $display("FAIL single_tx_width: got %b want 0", tx_external); errors++; end
        tick();
        checks++; if (state_out !== 3'd3) begin $display("FAIL single_wait_end: got %0d want 3", state_out); errors++; end
        wait_sig(2, 40, n);
        checks++; if (n !== 3 || done !== 2'b01 || err !== 2'b00 || grant !== 2'b00)
            begin $display("FAIL single_done: got n=%0d done=%b err=%b grant=%b want 3/01/00/00", n, done, err, grant); errors++; end
        req = '0;
        exp_ptr = 0;
        repeat (GAP_CYC + 2) tick();
    endtask

    task automatic test_round_robin();
        int n, sel;
        logic [7:0] lat;
        logic [NREQ-1:0] oh, newm;
        do_reset();
        resp_mode = 1;
        rdata[0] = 8'h11; rdata[1] = 8'h22; drive_data();
        req = 2'b11;
        for (int i = 0; i < 24; i++) begin
            sel = pick(req, exp_ptr);
            oh = 2'b01 << sel;
            busy_at = $urandom_range(0, 3);
            end_at = busy_at + $urandom_range(0, 6);
            wait_sig(0, 40, n);
            checks++; if (n !== (i == 0 ? 1 : GAP_CYC + 2)) begin $display("FAIL rr_gap: got %0d want %0d (round %0d)", n, (i == 0 ? 1 : GAP_CYC + 2), i); errors++; end
            checks++; if (grant !== oh) begin $display("FAIL rr_grant: got %b want %b (round %0d)", grant, oh, i); errors++; end
            checks++; if (to_uart !== rdata[sel]) begin $display("FAIL rr_data: got %h want %h (round %0d)", to_uart, rdata[sel], i); errors++; end
            lat = rdata[sel];
            wait_sig(1, 10, n);
            checks++; if (n !== 1) begin $display("FAIL rr_launch: got %0d want 1", n); errors++; end
            if (i >= 4) begin
                for (int j = 0; j < NREQ; j++) rdata[j] = 8'($urandom);
                drive_data();
                if ($urandom_range(0, 1) == 1) req = req & ~oh;
            end
            wait_sig(2, 40, n);
            checks++; if (n !== end_at + 1 || done !== oh || err !== 2'b00)
                begin $display("FAIL rr_done: got n=%0d done=%b err=%b want %0d/%b/00", n, done, err, end_at + 1, oh); errors++; end
            checks++; if (to_uart !== lat) begin $display("FAIL rr_hold: got %h want %h", to_uart, lat); errors++; end
            exp_ptr = sel;
            if (i >= 3) begin
                newm = req;
                if ($urandom_range(0, 1) == 1) newm = newm | oh; else newm = newm & ~oh;
                newm = newm | NREQ'($urandom_range(0, 3));
                if (newm == '0) newm = 2'b01 << $urandom_range(0, 1);
                req = newm;
            end
        end
        req = '0;
        repeat (GAP_CYC + 3) tick();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        resp_mode = 0;
        rdata[0] = 8'($urandom); rdata[1] = 8'($urandom); drive_data();
        req = 2'b11;
        wait_sig(0, 10, n);
        wait_sig(1, 10, n);
        wait_sig(2, TIMEOUT + 10, n);
        checks++; if (n !== TIMEOUT || err !== 2'b01 || done !== 2'b00)
            begin $display("FAIL to_err: got n=%0d err=%b done=%b want %0d/01/00", n, err, done, TIMEOUT); errors++; end
        checks++; if (grant !== 2'b00 || to_uart !== rdata[0])
            begin $display("FAIL to_release: got grant=%b data=%h want 00/%h", grant, to_uart, rdata[0]); errors++; end
        exp_ptr = 0;
        resp_mode = 1; busy_at = 0; end_at = 2;
        wait_sig(0, 20, n);
        checks++; if (n !== GAP_CYC + 2 || grant !== 2'b10 || to_uart !== rdata[1])
            begin $display("FAIL to_next: got n=%0d grant=%b data=%h want %0d/10/%h", n, grant, to_uart, GAP_CYC + 2, rdata[1]); errors++; end
        wait_sig(1, 10, n);
        wait_sig(2, 20, n);
        checks++; if (n !== end_at + 1 || done !== 2'b10) begin $display("FAIL to_next_done: got n=%0d done=%b want %0d/10", n, done, end_at + 1); errors++; end
        req = '0;
        repeat (GAP_CYC + 2) tick();
    endtask

    task automatic test_timeout_edge();
        int n;
        for (int e = TIMEOUT - 2; e <= TIMEOUT; e++) begin
            do_reset();
            resp_mode = 2; end_at = e;
            req = 2'b01;
            wait_sig(0, 10, n);
            wait_sig(1, 10, n);
            wait_sig(2, TIMEOUT + 10, n);
            checks++;
            if (n !== (e < TIMEOUT ? e + 1 : TIMEOUT) || done !== (e < TIMEOUT ? 2'b01 : 2'b00) ||
                err !== (e < TIMEOUT ? 2'b00 : 2'b01))
                begin $display("FAIL to_edge: got n=%0d done=%b err=%b for end offset %0d", n, done, err, e); errors++; end
            req = '0;
            repeat (GAP_CYC + 2) tick();
        end
    endtask

    task automatic test_end_in_wait_busy();
        int n, e;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            e = $urandom_range(0, 5);
            resp_mode = 2; end_at = e;
            req = 2'b10;
            wait_sig(0, 10, n);
            wait_sig(1, 10, n);
            repeat (e) tick();
            checks++; if (state_out !== 3'd2) begin $display("FAIL wb_state: got %0d want 2", state_out); errors++; end
            wait_sig(2, 10, n);
            checks++; if (n !== 1 || done !== 2'b10 || grant !== 2'b00 || err !== 2'b00)
                begin $display("FAIL wb_done: got n=%0d done=%b grant=%b err=%b want 1/10/00/00", n, done, grant, err); errors++; end
            req = '0;
            repeat (GAP_CYC + 2) tick();
        end
    endtask

    task automatic test_reset_mid();
        int n, sel;
        do_reset();
        resp_mode = 1; busy_at = 0; end_at = 40;
        rdata[0] = 8'($urandom); rdata[1] = 8'($urandom); drive_data();
        req = 2'b01;
        wait_sig(0, 10, n);
        wait_sig(1, 10, n);
        tick();
        checks++; if (state_out !== 3'd3) begin $display("FAIL mid_wait_end: got %0d want 3", state_out); errors++; end
        resp_mode = 0;
        #2 rst = 1'b1;
        #1;
        checks++; if (grant !== 2'b00 || done !== 2'b00 || err !== 2'b00 || tx_external !== 1'b0 ||
                      to_uart !== 8'h00 || state_out !== 3'd0)
            begin $display("FAIL mid_async: got g=%b d=%b e=%b tx=%b u=%h s=%0d want all 0", grant, done, err, tx_external, to_uart, state_out); errors++; end
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = NREQ - 1;
        resp_mode = 1; busy_at = 1; end_at = 3;
        req = 2'b10;
        wait_sig(0, 10, n);
        checks++; if (n !== 1 || grant !== 2'b10 || to_uart !== rdata[1])
            begin $display("FAIL mid_req10: got n=%0d grant=%b data=%h want 1/10/%h", n, grant, to_uart, rdata[1]); errors++; end
        wait_sig(1, 10, n);
        wait_sig(2, 20, n);
        checks++; if (n !== end_at + 1 || done !== 2'b10) begin $display("FAIL mid_done: got n=%0d done=%b want %0d/10", n, done, end_at + 1); errors++; end
        req = '0;
        do_reset();
        resp_mode = 1;
        req = 2'b11;
        sel = pick(req, exp_ptr);
        wait_sig(0, 10, n);
        checks++; if (n !== 1 || grant !== (2'b01 << sel)) begin $display("FAIL mid_req11: got %b want %b", grant, 2'b01 << sel); errors++; end
        wait_sig(1, 10, n);
        wait_sig(2, 20, n);
        req = '0;
        repeat (GAP_CYC + 2) tick();
    endtask

    task automatic test_spurious();
        do_reset();
        resp_mode = 3;
        repeat (12) begin
            tick();
            checks++; if (state_out !== 3'd0 || grant !== 2'b00 || tx_external !== 1'b0 || done !== 2'b00)
                begin $display("FAIL spurious: got s=%0d g=%b tx=%b d=%b want idle", state_out, grant, tx_external, done); errors++; end
        end
        resp_mode = 0;
    endtask

    task automatic test_invariants();
        checks++; if (viol !== 0) begin $display("FAIL onehot: got %0d violations want 0", viol); errors++; end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_timeout_edge();
        test_end_in_wait_busy();
        test_reset_mid();
        test_spurious();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
